// File: rtl/fetch_queue_if.sv
// Instruction-bus bundle between the fetch front end (master) and the memory system (slave).
// Split handshake: addr_ok accepts the request, data_ok returns the instruction.
interface fetch_queue_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with one outstanding bus request and a DEPTH-entry FIFO to decode.
// Redirects flush the FIFO and drop any in-flight response; misaligned PCs yield an error entry.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_queue_if.master        ibus,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic                 out_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          drop_q, drop_d;
  logic          halted_q, halted_d;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          err_mem   [DEPTH];

  logic          push;
  logic [31:0]   push_pc;
  logic [31:0]   push_instr;
  logic          push_err;
  logic          pop;
  logic          resp_done;
  logic          empty;
  logic          full;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;

  assign ibus.ireq_addr = req_addr_q;

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    req_addr_d      = req_addr_q;
    drop_d          = drop_q;
    halted_d        = halted_q;
    push            = 1'b0;
    push_pc         = fetch_pc_q;
    push_instr      = 32'd0;
    push_err        = 1'b0;
    resp_done       = 1'b0;
    ibus.ireq_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!halted_q && !full) begin
          if (fetch_pc_q[1:0] != 2'b00) begin
            push     = 1'b1;
            push_err = 1'b1;
            halted_d = 1'b1;
          end else begin
            req_addr_d = fetch_pc_q;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        ibus.ireq_valid = 1'b1;
        if (ibus.iresp_addr_ok) begin
          if (ibus.iresp_data_ok) begin
            resp_done = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (ibus.iresp_data_ok) begin
          resp_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resp_done) begin
      drop_d = 1'b0;
      if (!drop_q) begin
        push       = 1'b1;
        push_pc    = req_addr_q;
        push_instr = ibus.iresp_data;
        fetch_pc_d = req_addr_q + 32'd4;
      end
    end

    // A redirect overrides everything; an outstanding request stays on the bus but its data is
    // discarded, including a response landing in this very cycle.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      push       = 1'b0;
      if (state_q == StIdle) begin
        state_d    = StIdle;
        req_addr_d = req_addr_q;
      end else begin
        drop_d = !resp_done;
      end
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    if (redirect_valid) begin
      wptr_d = wptr_q;
      rptr_d = wptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wptr_q[AW-1:0]]    <= push_pc;
      instr_mem[wptr_q[AW-1:0]] <= push_instr;
      err_mem[wptr_q[AW-1:0]]   <= push_err;
    end
  end

  // Head is read straight from storage, so decode never sees a combinational path from the bus.
  assign out_valid = !empty;
  assign out_pc    = pc_mem[rptr_q[AW-1:0]];
  assign out_instr = instr_mem[rptr_q[AW-1:0]];
  assign out_err   = !empty && err_mem[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a reactive bus model predicts FIFO contents into a scoreboard,
// a per-cycle vector table covers start-up timing, and short sequences cover redirects.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_err;

  fetch_queue_if bus ();

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .ibus          (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  typedef struct {
    logic        ready;
    logic        ivalid;
    logic [31:0] iaddr;
    logic        ovalid;
    logic [31:0] opc;
  } vec_t;

  entry_t      sb[$];
  entry_t      e_pop;
  int          n_pass = 0;
  int          n_total = 0;

  int          stall_knob = 0;
  int          lat_knob = 0;
  bit          rand_bus = 1'b0;
  int          stall_cnt = 0;
  int          pend_cnt = 0;
  int          lat;
  bit          pend = 1'b0;
  bit          held = 1'b0;
  bit          req_drop = 1'b0;
  bit          inflight;
  bit          done;
  logic [31:0] pend_addr;
  logic [31:0] held_addr;
  logic [31:0] done_addr;
  logic [31:0] exp_fetch_pc = RESET_PC;
  int          hs_count = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hdead_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Bus slave + predictor. Decisions made here take effect at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    if (reset) begin
      pend         = 1'b0;
      held         = 1'b0;
      req_drop     = 1'b0;
      stall_cnt    = stall_knob;
      exp_fetch_pc = RESET_PC;
      sb.delete();
    end else begin
      inflight = pend || bus.ireq_valid;
      done     = 1'b0;
      if (bus.ireq_valid) begin
        if (held) check("ireq_addr_held", bus.ireq_addr, held_addr);
        else check("ireq_addr_new", bus.ireq_addr, exp_fetch_pc);
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.iresp_data_ok = 1'b1;
          bus.iresp_data    = instr_of(pend_addr);
          done              = 1'b1;
          done_addr         = pend_addr;
          pend              = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if (bus.ireq_valid) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          lat = rand_bus ? int'($urandom_range(3, 0)) : lat_knob;
          bus.iresp_addr_ok = 1'b1;
          hs_count++;
          if (lat == 0) begin
            bus.iresp_data_ok = 1'b1;
            bus.iresp_data    = instr_of(bus.ireq_addr);
            done              = 1'b1;
            done_addr         = bus.ireq_addr;
          end else begin
            pend      = 1'b1;
            pend_addr = bus.ireq_addr;
            pend_cnt  = lat - 1;
          end
          stall_cnt = rand_bus ? int'($urandom_range(2, 0)) : stall_knob;
        end
      end
      held      = bus.ireq_valid && !bus.iresp_addr_ok;
      held_addr = bus.ireq_addr;

      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          e_pop = sb.pop_front();
          check("head_pc", out_pc, e_pop.pc);
          check("head_instr", out_instr, e_pop.instr);
          check("head_err", {31'd0, out_err}, {31'd0, e_pop.err});
        end
      end
      if (redirect_valid && inflight) req_drop = 1'b1;
      if (done) begin
        if (!req_drop) begin
          sb.push_back('{done_addr, instr_of(done_addr), 1'b0});
          exp_fetch_pc = done_addr + 32'd4;
        end
        req_drop = 1'b0;
      end
      if (redirect_valid) begin
        sb.delete();
        exp_fetch_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) sb.push_back('{redirect_pc, 32'd0, 1'b1});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ireq_valid", {31'd0, bus.ireq_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
  endtask

  task automatic wait_ireq(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ireq_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_out(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   hs_start;
    int   vcnt;
    int   pops;

    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;

    // Zero-wait bus start-up: {out_ready, ireq_valid, ireq_addr, out_valid, out_pc}
    vecs[0] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'hbfc0_0000, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0000};
    vecs[3] = '{1'b0, 1'b1, 32'hbfc0_0004, 1'b1, 32'hbfc0_0000};
    vecs[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0000};
    vecs[5] = '{1'b1, 1'b1, 32'hbfc0_0008, 1'b1, 32'hbfc0_0004};
    vecs[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008};
    vecs[7] = '{1'b0, 1'b1, 32'hbfc0_000c, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_000c};

    stall_knob = 0;
    lat_knob   = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = vecs[i].ready;
      #2;
      check($sformatf("vec%0d_ireq_valid", i), {31'd0, bus.ireq_valid}, {31'd0, vecs[i].ivalid});
      if (vecs[i].ivalid) check($sformatf("vec%0d_ireq_addr", i), bus.ireq_addr, vecs[i].iaddr);
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ovalid});
      if (vecs[i].ovalid) begin
        check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].opc);
        check($sformatf("vec%0d_out_instr", i), out_instr, instr_of(vecs[i].opc));
      end
    end

    // Fill with decode stalled: exactly DEPTH requests, then the bus goes quiet.
    do_reset();
    hs_start = hs_count;
    repeat (30) @(negedge clk);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ireq_valid) vcnt++;
      @(negedge clk);
    end
    check("fill_requests", hs_count - hs_start, DEPTH);
    check("fill_quiet", vcnt, 0);
    check("fill_out_valid", {31'd0, out_valid}, 32'd1);
    check("fill_head_pc", out_pc, RESET_PC);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Redirect while the second request waits for a slow response.
    lat_knob = 3;
    do_reset();
    wait_out("wait_first_entry");
    wait_ireq("wait_second_req");
    @(negedge clk);
    check("wait_state_valid", {31'd0, bus.ireq_valid}, 32'd0);
    pulse_redirect(32'h8000_1000);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    wait_out("wait_redir_wait");
    check("redir_wait_pc", out_pc, 32'h8000_1000);
    check("redir_wait_instr", out_instr, instr_of(32'h8000_1000));

    // Redirect while addr_ok is withheld: request stays on the bus unchanged.
    stall_knob = 4;
    lat_knob   = 0;
    do_reset();
    out_ready = 1'b1;
    wait_ireq("wait_req_stalled");
    pulse_redirect(32'h8000_3000);
    check("redir_req_held_valid", {31'd0, bus.ireq_valid}, 32'd1);
    check("redir_req_held_addr", bus.ireq_addr, RESET_PC);
    wait_out("wait_redir_req");
    check("redir_req_pc", out_pc, 32'h8000_3000);

    // Misaligned target: error entry, no bus traffic, until a fresh redirect.
    stall_knob = 0;
    do_reset();
    repeat (3) @(negedge clk);
    pulse_redirect(32'h8000_1002);
    wait_out("wait_misaligned");
    check("mis_err", {31'd0, out_err}, 32'd1);
    check("mis_instr", out_instr, 32'd0);
    check("mis_pc", out_pc, 32'h8000_1002);
    hs_start = hs_count;
    repeat (10) @(negedge clk);
    check("mis_no_request", hs_count - hs_start, 0);
    check("mis_hold_valid", {31'd0, out_valid}, 32'd1);
    pulse_redirect(32'h8000_2000);
    out_ready = 1'b1;
    wait_out("wait_resume");
    check("resume_pc", out_pc, 32'h8000_2000);
    check("resume_err", {31'd0, out_err}, 32'd0);

    // Randomised stalls starting from a full FIFO; the predictor checks order on every pop.
    rand_bus = 1'b1;
    do_reset();
    repeat (40) @(negedge clk);
    check("rand_full_head", out_pc, RESET_PC);
    pops = 0;
    for (int i = 0; i < 600 && pops < 20; i++) begin
      out_ready = 1'($urandom_range(1, 0));
      if (out_valid && out_ready) pops++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("rand_pops", pops, 20);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
